xor_unit_sched: RTL

//  Shares one registered XOR datapath (c = a ^ b) among NREQ requesters.

---
 rtl/xor_unit_sched_if.sv | 26 ++
 rtl/xor_unit_sched.sv | 102 ++++++++++
 2 files changed

// File: rtl/xor_unit_sched_if.sv
// Request/response bundle for the shared XOR scheduler.
// The master side is the requesters plus the response consumer; the slave side is the scheduler.
interface xor_unit_sched_if #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned IDW  = 2
) ();
  logic [NREQ-1:0]    req_valid;
  logic [NREQ*DW-1:0] req_a;
  logic [NREQ*DW-1:0] req_b;
  logic [NREQ-1:0]    req_ready;
  logic               rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic [IDW-1:0]     rsp_id;
  logic               rsp_ready;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );
endinterface

// File: rtl/xor_unit_sched.sv
// Round-robin scheduler sharing one registered XOR datapath among NREQ requesters.
// Each operation takes three cycles: grant/capture, compute, then hold the response until it is taken.
module xor_unit_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned IDW  = 2,
  parameter int unsigned CNTW = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  xor_unit_sched_if.slave bus,
  output logic            busy,
  output logic [CNTW-1:0] op_count
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] rr_ptr;
  logic [DW-1:0]  a_q, b_q;
  logic [IDW-1:0] id_q;
  logic [DW-1:0]  rsp_data_q;
  logic [IDW-1:0] rsp_id_q;
  logic           rsp_valid_q;

  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  win;
  logic [IDW-1:0]  idx;
  logic            found;

  // Search starts at rr_ptr and wraps modulo NREQ, which need not be a power of two.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IDW'((32'(rr_ptr) + k) % NREQ);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  always_comb begin
    state_nx = state;
    grant    = '0;
    case (state)
      IDLE: begin
        if (rst_n && found) begin
          grant[win] = 1'b1;
          state_nx   = EXEC;
        end
      end
      EXEC:    state_nx = RESP;
      RESP:    if (bus.rsp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_valid_q <= 1'b0;
      op_count    <= '0;
    end else begin
      state       <= state_nx;
      rsp_valid_q <= (state_nx == RESP);
      case (state)
        IDLE: begin
          if (state_nx == EXEC) begin
            a_q    <= bus.req_a[32'(win)*DW +: DW];
            b_q    <= bus.req_b[32'(win)*DW +: DW];
            id_q   <= win;
            rr_ptr <= IDW'((32'(win) + 1) % NREQ);
          end
        end
        EXEC: begin
          rsp_data_q <= a_q ^ b_q;
          rsp_id_q   <= id_q;
        end
        RESP: begin
          if (bus.rsp_ready) op_count <= op_count + CNTW'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_id    = rsp_id_q;
  assign busy          = (state != IDLE);

endmodule
